// File: rtl/gate_tester_if.sv
// Gate-under-test connection: input vector out to the gate, gate output back.
// master = tester side, slave = gate side.
interface gate_tester_if #(
    parameter int N_IN = 2
);
    logic [N_IN-1:0] dut_a;
    logic            dut_out;

    modport master (
        output dut_a,
        input  dut_out
    );

    modport slave (
        input  dut_a,
        output dut_out
    );
endinterface

// File: rtl/gate_tester.sv
// Sweeps every input vector onto a combinational gate and checks its output
// against TRUTH. Optional macro STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module gate_tester #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    gate_tester_if.master   gif,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]      SETTLE_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
    localparam logic [N_IN:0]   ERR_ONE   = 1;
    localparam logic [N_IN-1:0] VEC_ONE   = 1;
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] dut_a_q;
    logic [N_IN-1:0] first_fail_q;
    logic [N_IN:0]   err_q;
    logic [N_IN:0]   err_d;
    logic [7:0]      cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            miss;
    logic            stop;

    // Compare the gate against the truth table and decide whether this vector ends the sweep.
    always_comb begin
        miss  = (gif.dut_out != TRUTH[vec_q]);
        err_d = miss ? (err_q + ERR_ONE) : err_q;
`ifdef STOP_ON_FAIL_EN
        stop  = (vec_q == VEC_LAST) || miss;
`else
        stop  = (vec_q == VEC_LAST);
`endif
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            dut_a_q      <= '0;
            first_fail_q <= '0;
            err_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q        <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        vec_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    dut_a_q <= vec_q;
                    if (SETTLE > 0) begin
                        cnt_q   <= SETTLE_LD;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_CHECK: begin
                    err_q <= err_d;
                    if (miss && (err_q == '0)) begin
                        first_fail_q <= vec_q;
                    end
                    if (stop) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= S_DONE;
                    end else begin
                        vec_q   <= vec_q + VEC_ONE;
                        state_q <= S_APPLY;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gif.dut_a  = dut_a_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_fail_q;

endmodule
